rt_shift_ctrl: RTL and testbench
================================

# rt_shift_ctrl

Shift-pulse initiator for a racetrack memory track built from shift cells. Each request names a target domain position. The block drives the track's shared shift-direction and shift-strobe currents (`current_s`, `current_m`) until that domain sits under the access port. It then samples the port bit and returns it on a valid/ready response channel. It sits between the memory-side request logic and the racetrack array, and it is the only agent that moves the track.

## Interface
Parameters:
- `N_POS`, 64: number of track positions; legal offsets are 0..N_POS-1.
- `PW`, `$clog2(N_POS)`: width of position fields.
- `PULSE_W`, 2: cycles `current_m_o` is held high per shift (≥1).
- `GAP_W`, 1: cycles `current_m_o` is held low between shifts (≥1).
- `SETTLE_W`, 1: cycles waited after the last shift before sampling (≥0).

Ports:
- `clk_i`, in, 1: clock.
- `rstn`, in, 1: reset; asynchronous, active-low.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when high together with `req_valid_i` at a rising `clk_i` edge.
- `req_pos_i`, in, PW: target offset.
- `current_s_o`, out, 1: shift direction; 0 = forward (offset +1), 1 = backward (offset −1).
- `current_m_o`, out, 1: shift strobe; each rising edge commits one shift in every cell.
- `port_bit_i`, in, 1: cell output at the access port.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response consumed.
- `rsp_data_o`, out, 1: sampled port bit.
- `rsp_err_o`, out, 1: target was out of range; no shift was issued.
- `pos_o`, out, PW: current track offset.

## Operation
- FSM states: IDLE, SETUP, PULSE_HI, PULSE_LO, SETTLE, SAMPLE, RESP.
- `req_ready_o` is 1 only in IDLE.
- Accept with `req_pos_i` ≥ N_POS: go to RESP with `rsp_err_o`=1 and `rsp_data_o`=0. Offset and currents are unchanged.
- Accept with target == `pos_o`: go to SETTLE (or to SAMPLE if SETTLE_W=0). No pulses are issued.
- Otherwise: latch the target and set `current_s_o` = (target < `pos_o`). Then go to SETUP.
- SETUP lasts 1 cycle with `current_m_o`=0 and the direction stable.
- PULSE_HI lasts PULSE_W cycles with `current_m_o`=1.
  - `pos_o` updates by ±1 on the entry edge, i.e. coincident with the strobe rising.
- PULSE_LO lasts GAP_W cycles with `current_m_o`=0.
- From PULSE_LO: if `pos_o` ≠ target, go to PULSE_HI; otherwise go to SETTLE.
- SETTLE lasts SETTLE_W cycles.
- SAMPLE lasts 1 cycle and registers `port_bit_i` into `rsp_data_o`.
- RESP holds `rsp_valid_o`=1 and the data stable until `rsp_ready_i`=1, then returns to IDLE.
- `current_s_o` is constant for the whole request and changes only when `current_m_o`=0.
- `current_m_o` is driven directly from a flop, never combinationally.
- Offset never wraps. The range check makes 0−1 and N_POS−1+1 unreachable.

## Timing
- Reset values:
  - FSM = IDLE
  - `pos_o`=0, `current_s_o`=0, `current_m_o`=0
  - `req_ready_o`=1
  - `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0
- Reset asserted mid-pulse forces `current_m_o` low asynchronously.
  - This falling edge commits no shift.
  - The cells reset with the same `rstn`, so offset 0 stays consistent with the array.
- With k = |target − pos| shifts, `rsp_valid_o` rises this many cycles after the accept edge:
  - k>0: 1 + k·(PULSE_W+GAP_W) + SETTLE_W + 1
  - k=0: SETTLE_W + 1
  - error: 1
- Throughput: the next request is accepted no earlier than the cycle after the RESP handshake. Accepts are never overlapped.

## Configuration
- `RT_SHIFT_CNT_EN` defined: adds the output `shift_cnt_o[31:0]`.
  - Reset value 0.
  - Increments on every PULSE_HI entry.
  - Saturates at 32'hFFFF_FFFF.
- `RT_SHIFT_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset, then request pos 3 -> 3 strobes with `current_s_o`=0, each 2 high / 1 low. `pos_o` goes 1, 2, 3. `rsp_valid_o` rises 12 cycles after accept, with `rsp_data_o` = `port_bit_i` at SAMPLE.
- From pos 3, request pos 1 -> `current_s_o`=1 during SETUP, 2 strobes, `pos_o`=1, response 9 cycles after accept.
- From pos 1, request pos 1 -> no strobe, response 2 cycles after accept. Request pos 70 (needs PW=7 stimulus; with PW=6 use N_POS=40 and pos 50) -> `rsp_err_o`=1 after 1 cycle, `pos_o` unchanged.
- Hold `rsp_ready_i`=0 for 5 cycles -> `rsp_valid_o` and `rsp_data_o` stay stable, `req_ready_o`=0 throughout. Handshake then gives IDLE on the next cycle.
- Assert `rstn` low during the 2nd PULSE_HI of a 4-shift request -> `current_m_o` drops immediately and `pos_o`=0. After release, a request to pos 2 completes normally.
- With `RT_SHIFT_CNT_EN`, the above sequence (3+2 shifts) -> `shift_cnt_o`=5.

Source files
------------

// File: rtl/rt_shift_ctrl.sv
// rt_shift_ctrl: shift-pulse initiator for one racetrack memory track.
//
// A request names a target domain offset. The block drives the shared shift
// direction (current_s_o) and shift strobe (current_m_o) until that domain sits
// under the access port. It then samples port_bit_i and returns the bit on a
// valid/ready response channel. Out-of-range targets issue no shift and answer
// with rsp_err_o=1.
//
// Ports:
//   clk_i, rstn                       clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_pos_i request channel (target offset)
//   current_s_o                       direction: 0 = forward (+1), 1 = backward (-1)
//   current_m_o                       strobe, each rising edge commits one shift
//   port_bit_i                        cell output at the access port
//   rsp_valid_o/rsp_ready_i           response channel
//   rsp_data_o, rsp_err_o             sampled bit, out-of-range flag
//   pos_o                             current track offset
//   shift_cnt_o                       saturating shift count (RT_SHIFT_CNT_EN only)
//
// Optional feature macro: RT_SHIFT_CNT_EN adds shift_cnt_o[31:0].
module rt_shift_ctrl #(
  parameter int N_POS    = 64,
  parameter int PW       = $clog2(N_POS),
  parameter int PULSE_W  = 2,
  parameter int GAP_W    = 1,
  parameter int SETTLE_W = 1
) (
  input  logic          clk_i,
  input  logic          rstn,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [PW-1:0] req_pos_i,
  output logic          current_s_o,
  output logic          current_m_o,
  input  logic          port_bit_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_data_o,
  output logic          rsp_err_o,
  output logic [PW-1:0] pos_o
`ifdef RT_SHIFT_CNT_EN
  ,
  output logic [31:0]   shift_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_PULSE_LO = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_SAMPLE   = 3'd5,
    ST_RESP     = 3'd6
  } state_e;

  localparam logic [PW:0] NPOS_L = (PW+1)'(N_POS);
  // Where to go once the domain is in place; SETTLE is skipped when SETTLE_W=0.
  localparam state_e ST_AFTER_SHIFT = (SETTLE_W == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e        state_r, state_nxt_s;
  logic [15:0]   cnt_r;
  logic [PW-1:0] tgt_r, tgt_nxt_s;
  logic          err_r, err_nxt_s;
  logic [PW-1:0] pos_r, pos_nxt_s;
  logic          dir_r, dir_nxt_s;
  logic          strobe_r, strobe_nxt_s;
  logic          ready_r, ready_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          data_r, data_nxt_s;
  logic          rerr_r, rerr_nxt_s;

  logic accept_s, range_err_s, same_s, step_s;
  logic pulse_done_s, gap_done_s, settle_done_s;

  assign accept_s      = (state_r == ST_IDLE) && req_valid_i;
  assign range_err_s   = ({1'b0, req_pos_i} >= NPOS_L);
  assign same_s        = (req_pos_i == pos_r);
  // One shift is committed on every entry into PULSE_HI.
  assign step_s        = (state_r != ST_PULSE_HI) && (state_nxt_s == ST_PULSE_HI);
  assign pulse_done_s  = (cnt_r == 16'(PULSE_W - 1));
  assign gap_done_s    = (cnt_r == 16'(GAP_W - 1));
  assign settle_done_s = (cnt_r == 16'(SETTLE_W - 1));

  // State register, per-state cycle counter and registered outputs.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 16'd0;
      tgt_r    <= '0;
      err_r    <= 1'b0;
      pos_r    <= '0;
      dir_r    <= 1'b0;
      strobe_r <= 1'b0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      data_r   <= 1'b0;
      rerr_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= (state_nxt_s != state_r) ? 16'd0 : cnt_r + 16'd1;
      tgt_r    <= tgt_nxt_s;
      err_r    <= err_nxt_s;
      pos_r    <= pos_nxt_s;
      dir_r    <= dir_nxt_s;
      strobe_r <= strobe_nxt_s;
      ready_r  <= ready_nxt_s;
      valid_r  <= valid_nxt_s;
      data_r   <= data_nxt_s;
      rerr_r   <= rerr_nxt_s;
    end
  end

  // Next-state logic. Out-of-range requests pass through SAMPLE (with the
  // sampled bit suppressed) so the error answer appears one cycle after accept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (range_err_s)  state_nxt_s = ST_SAMPLE;
          else if (same_s)  state_nxt_s = ST_AFTER_SHIFT;
          else              state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP:    state_nxt_s = ST_PULSE_HI;
      ST_PULSE_HI: begin
        if (pulse_done_s) state_nxt_s = ST_PULSE_LO;
        else              state_nxt_s = ST_PULSE_HI;
      end
      ST_PULSE_LO: begin
        if (!gap_done_s)          state_nxt_s = ST_PULSE_LO;
        else if (pos_r != tgt_r)  state_nxt_s = ST_PULSE_HI;
        else                      state_nxt_s = ST_AFTER_SHIFT;
      end
      ST_SETTLE: begin
        if (settle_done_s) state_nxt_s = ST_SAMPLE;
        else               state_nxt_s = ST_SETTLE;
      end
      ST_SAMPLE: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of every registered output, so the strobe
  // and the offset change on the same edge that enters PULSE_HI.
  always_comb begin
    ready_nxt_s  = (state_nxt_s == ST_IDLE);
    valid_nxt_s  = (state_nxt_s == ST_RESP);
    strobe_nxt_s = (state_nxt_s == ST_PULSE_HI);

    if (accept_s) begin
      tgt_nxt_s = req_pos_i;
      err_nxt_s = range_err_s;
    end else begin
      tgt_nxt_s = tgt_r;
      err_nxt_s = err_r;
    end

    // Direction only moves at accept, while the strobe is low.
    if (accept_s && !range_err_s && !same_s) dir_nxt_s = (req_pos_i < pos_r);
    else                                     dir_nxt_s = dir_r;

    if (step_s) pos_nxt_s = dir_r ? (pos_r - PW'(1)) : (pos_r + PW'(1));
    else        pos_nxt_s = pos_r;

    if (state_r == ST_SAMPLE) begin
      data_nxt_s = err_r ? 1'b0 : port_bit_i;
      rerr_nxt_s = err_r;
    end else if ((state_r == ST_RESP) && rsp_ready_i) begin
      data_nxt_s = 1'b0;
      rerr_nxt_s = 1'b0;
    end else begin
      data_nxt_s = data_r;
      rerr_nxt_s = rerr_r;
    end
  end

  assign req_ready_o = ready_r;
  assign rsp_valid_o = valid_r;
  assign rsp_data_o  = data_r;
  assign rsp_err_o   = rerr_r;
  assign current_m_o = strobe_r;
  assign current_s_o = dir_r;
  assign pos_o       = pos_r;

`ifdef RT_SHIFT_CNT_EN
  logic [31:0] shift_cnt_r;

  // Saturating count of committed shifts.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      shift_cnt_r <= 32'd0;
    end else if (step_s && (shift_cnt_r != 32'hFFFF_FFFF)) begin
      shift_cnt_r <= shift_cnt_r + 32'd1;
    end else begin
      shift_cnt_r <= shift_cnt_r;
    end
  end

  assign shift_cnt_o = shift_cnt_r;
`else
  // Shift counter not built.
`endif

endmodule

// File: tb/tb_rt_shift_ctrl.sv
module tb_rt_shift_ctrl;
  localparam int N_POS = 40;
  localparam int PW    = 6;

  logic          clk_i = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [PW-1:0] req_pos_i = '0;
  logic          current_s_o;
  logic          current_m_o;
  logic          port_bit_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_data_o;
  logic          rsp_err_o;
  logic [PW-1:0] pos_o;
`ifdef RT_SHIFT_CNT_EN
  logic [31:0]   shift_cnt_o;
`endif

  // Bit pattern stored on the track: offsets 2 and 3 hold 1, the rest 0.
  logic [63:0] track = 64'h0000_0000_0000_000C;
  assign port_bit_i = track[pos_o];

  rt_shift_ctrl #(.N_POS(N_POS)) dut (
    .clk_i       (clk_i),
    .rstn        (rstn),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_pos_i   (req_pos_i),
    .current_s_o (current_s_o),
    .current_m_o (current_m_o),
    .port_bit_i  (port_bit_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .pos_o       (pos_o)
`ifdef RT_SHIFT_CNT_EN
    ,
    .shift_cnt_o (shift_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          data;
    logic          err;
    logic [PW-1:0] pos;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   strobe_total = 0;
  logic exp_dir = 1'b0;
  logic prev_valid = 1'b0;
  int   hi_run = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Strobe monitor: count rising strobes and check the direction they commit.
  always @(posedge current_m_o) begin
    #1;
    strobe_total <= strobe_total + 1;
    chk("strobe_dir", current_s_o, exp_dir);
  end

  // Response monitor: pop and compare on each rising rsp_valid_o; also check strobe width.
  always @(negedge clk_i) begin
    if (!rstn) begin
      prev_valid <= 1'b0;
      hi_run     <= 0;
    end else begin
      if (rsp_valid_o && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_data", rsp_data_o, sb_q[0].data);
          chk("rsp_err", rsp_err_o, sb_q[0].err);
          chk("rsp_pos", pos_o, sb_q[0].pos);
          chk("rsp_latency", cyc - acc_cyc, sb_q[0].lat);
          void'(sb_q.pop_front());
        end
      end
      prev_valid <= rsp_valid_o;
      if (current_m_o) begin
        hi_run <= hi_run + 1;
      end else if (hi_run != 0) begin
        chk("strobe_high_cycles", hi_run, 2);
        hi_run <= 0;
      end
    end
  end

  task automatic do_req(input int pos, input logic d, input logic e, input int p,
                        input int lat, input int nstr, input logic dir, input int hold);
    exp_t item;
    int   base;
    int   t;
    @(negedge clk_i);
    chk("req_ready_idle", req_ready_o, 1);
    exp_dir   = dir;
    base      = strobe_total;
    item.data = d;
    item.err  = e;
    item.pos  = PW'(p);
    item.lat  = lat;
    sb_q.push_back(item);
    req_valid_i = 1'b1;
    req_pos_i   = PW'(pos);
    @(negedge clk_i);
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
    t = 0;
    while (!rsp_valid_o && t < 60) begin
      @(negedge clk_i);
      t++;
    end
    if (!rsp_valid_o) begin
      chk("rsp_timeout", 0, 1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        chk("hold_valid", rsp_valid_o, 1);
        chk("hold_data", rsp_data_o, d);
        chk("hold_err", rsp_err_o, e);
        chk("hold_req_ready", req_ready_o, 0);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("idle_after_handshake", req_ready_o, 1);
      chk("valid_after_handshake", rsp_valid_o, 0);
    end
    chk("strobe_count", strobe_total - base, nstr);
  endtask

  // Four-shift request from offset 1, reset asserted in the second PULSE_HI.
  task automatic do_abort();
    int base;
    int t;
    @(negedge clk_i);
    exp_dir     = 1'b0;
    base        = strobe_total;
    req_valid_i = 1'b1;
    req_pos_i   = PW'(5);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    t = 0;
    while ((strobe_total - base) < 2 && t < 40) begin
      @(negedge clk_i);
      t++;
    end
    chk("abort_second_pulse_reached", strobe_total - base, 2);
    chk("abort_strobe_high_before_reset", current_m_o, 1);
    rstn = 1'b0;
    #1;
    chk("abort_strobe_low", current_m_o, 0);
    chk("abort_pos", pos_o, 0);
    chk("abort_dir", current_s_o, 0);
    chk("abort_req_ready", req_ready_o, 1);
    chk("abort_rsp_valid", rsp_valid_o, 0);
    repeat (2) @(negedge clk_i);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_pos", pos_o, 0);
    chk("reset_dir", current_s_o, 0);
    chk("reset_strobe", current_m_o, 0);
    chk("reset_req_ready", req_ready_o, 1);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_rsp_data", rsp_data_o, 0);
    chk("reset_rsp_err", rsp_err_o, 0);
    rstn = 1'b1;

    // pos 0 -> 3: forward, 3 strobes, 1 + 3*3 + 1 + 1 = 12 cycles, bit 3 = 1
    do_req(3, 1'b1, 1'b0, 3, 12, 3, 1'b0, 0);
    // pos 3 -> 1: backward, 2 strobes, 1 + 2*3 + 1 + 1 = 9 cycles, bit 1 = 0
    do_req(1, 1'b0, 1'b0, 1, 9, 2, 1'b1, 0);
    // pos 1 -> 1: no strobe, 1 + 1 = 2 cycles
    do_req(1, 1'b0, 1'b0, 1, 2, 0, 1'b1, 0);
    // pos 50 >= N_POS: error after 1 cycle, offset unchanged, held 5 cycles
    do_req(50, 1'b0, 1'b1, 1, 1, 0, 1'b1, 5);
`ifdef RT_SHIFT_CNT_EN
    chk("shift_cnt", shift_cnt_o, 5);
`endif
    do_abort();
    chk("post_reset_pos", pos_o, 0);
    // pos 0 -> 2 after the abort: 2 strobes, 9 cycles, bit 2 = 1
    do_req(2, 1'b1, 1'b0, 2, 9, 2, 1'b0, 0);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
